// File: rtl/clk_en_gen.sv
// clk_en_gen: lock-debounced, multi-channel NCO clock-enable generator in the clk100 domain.
// Optional: define CLK_EN_GEN_LOCK_SYNC_EN to pass locked_in through a 2-flop synchroniser.
module clk_en_gen #(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned ACC_W       = 32,
  parameter int unsigned LOCK_CYCLES = 1024
) (
  input  logic                    clk100,
  input  logic                    rst,
  input  logic                    locked_in,
  input  logic [NUM_CH*ACC_W-1:0] inc,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic                    clr_lost,
  output logic                    ready,
  output logic [NUM_CH-1:0]       tick,
  output logic                    lock_lost
);

  localparam int unsigned CntW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {
    StWaitLock,
    StSettle,
    StRun
  } state_e;

  logic w_lock_s;

`ifdef CLK_EN_GEN_LOCK_SYNC_EN
  logic [1:0] r_sync;

  always_ff @(posedge clk100) begin
    if (rst) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], locked_in};
    end
  end

  assign w_lock_s = r_sync[1];
`else
  assign w_lock_s = locked_in;
`endif

  state_e          r_state, w_state_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic            w_lost_event;
  logic            r_lock_lost;
  logic            w_run;

  always_comb begin
    w_state_d    = r_state;
    w_cnt_d      = r_cnt;
    w_lost_event = 1'b0;
    case (r_state)
      StWaitLock: begin
        if (w_lock_s) begin
          w_state_d = StSettle;
          w_cnt_d   = '0;
        end
      end
      StSettle: begin
        if (!w_lock_s) begin
          w_state_d = StWaitLock;
          w_cnt_d   = '0;
        end else if (r_cnt == CntLast) begin
          w_state_d = StRun;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      StRun: begin
        if (!w_lock_s) begin
          w_state_d    = StWaitLock;
          w_cnt_d      = '0;
          w_lost_event = 1'b1;
        end
      end
      default: begin
        w_state_d = StWaitLock;
        w_cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk100) begin
    if (rst) begin
      r_state <= StWaitLock;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  // A loss event on the same edge as clr_lost must leave the flag set.
  always_ff @(posedge clk100) begin
    if (rst) begin
      r_lock_lost <= 1'b0;
    end else if (w_lost_event) begin
      r_lock_lost <= 1'b1;
    end else if (clr_lost) begin
      r_lock_lost <= 1'b0;
    end
  end

  // Accumulators only advance on edges that stay in RUN; the exit edge clears them.
  assign w_run = (r_state == StRun) && w_lock_s;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [ACC_W-1:0] r_acc;
    logic             r_tick;
    logic [ACC_W:0]   w_sum;

    assign w_sum = {1'b0, r_acc} + {1'b0, inc[g*ACC_W +: ACC_W]};

    always_ff @(posedge clk100) begin
      if (rst || !w_run) begin
        r_acc  <= '0;
        r_tick <= 1'b0;
      end else if (ch_en[g]) begin
        r_acc  <= w_sum[ACC_W-1:0];
        r_tick <= w_sum[ACC_W];
      end else begin
        r_tick <= 1'b0;
      end
    end

    assign tick[g] = r_tick;
  end

  assign ready     = (r_state == StRun);
  assign lock_lost = r_lock_lost;

endmodule

// File: tb/tb_clk_en_gen.sv
// tb_clk_en_gen: directed self-checking bench for clk_en_gen (ACC_W=8 main DUT, ACC_W=32 rate DUT).
module tb_clk_en_gen;

`ifdef CLK_EN_GEN_LOCK_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif
  localparam int          FRAC_N   = 20000;
  localparam logic [31:0] FRAC_INC = 32'd180143985;

  logic        clk;
  logic        rst;
  logic        locked_in;
  logic [15:0] inc;
  logic [1:0]  ch_en;
  logic        clr_lost;
  logic        ready;
  logic [1:0]  tick;
  logic        lock_lost;

  logic        f_rst;
  logic        f_locked;
  logic [31:0] f_inc;
  logic [0:0]  f_ch_en;
  logic        f_clr;
  logic        f_ready;
  logic [0:0]  f_tick;
  logic        f_lost;

  int checks = 0;
  int errors = 0;

  clk_en_gen #(.NUM_CH(2), .ACC_W(8), .LOCK_CYCLES(16)) u_dut (
    .clk100   (clk),
    .rst      (rst),
    .locked_in(locked_in),
    .inc      (inc),
    .ch_en    (ch_en),
    .clr_lost (clr_lost),
    .ready    (ready),
    .tick     (tick),
    .lock_lost(lock_lost)
  );

  clk_en_gen #(.NUM_CH(1), .ACC_W(32), .LOCK_CYCLES(16)) u_frac (
    .clk100   (clk),
    .rst      (f_rst),
    .locked_in(f_locked),
    .inc      (f_inc),
    .ch_en    (f_ch_en),
    .clr_lost (f_clr),
    .ready    (f_ready),
    .tick     (f_tick),
    .lock_lost(f_lost)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reset, then hold lock until ready has just risen (no checks here).
  task automatic bring_up();
    rst = 1'b1; locked_in = 1'b0; clr_lost = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; locked_in = 1'b1;
    repeat (17 + SYNC) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; locked_in = 1'b1; clr_lost = 1'b0; inc = 16'hFFFF; ch_en = 2'b11;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (ready !== 1'b0 || tick !== 2'b00 || lock_lost !== 1'b0) begin
      errors++;
      $display("FAIL reset: ready=%b tick=%b lock_lost=%b, required 0 00 0", ready, tick, lock_lost);
    end
  endtask

  task automatic test_lockup();
    rst = 1'b1; locked_in = 1'b0; inc = 16'h8040; ch_en = 2'b11;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0; locked_in = 1'b1;
    for (int e = 1; e <= 17 + SYNC; e++) begin
      @(posedge clk);
      #1;
      checks++;
      if (ready !== (e == 17 + SYNC) || tick !== 2'b00) begin
        errors++;
        $display("FAIL lockup edge %0d: ready=%b tick=%b, required ready=%b tick=00",
                 e, ready, tick, (e == 17 + SYNC));
      end
    end
  endtask

  task automatic test_glitch();
    rst = 1'b1; locked_in = 1'b0; inc = 16'h0000; ch_en = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; locked_in = 1'b1;
    for (int e = 1; e <= 29 + SYNC; e++) begin
      @(posedge clk);
      #1;
      checks++;
      if (ready !== (e == 29 + SYNC) || lock_lost !== 1'b0) begin
        errors++;
        $display("FAIL glitch edge %0d: ready=%b lock_lost=%b, required ready=%b lock_lost=0",
                 e, ready, lock_lost, (e == 29 + SYNC));
      end
      if (e == 11) locked_in = 1'b0;
      if (e == 12) locked_in = 1'b1;
    end
  endtask

  task automatic test_integer_rate();
    logic [1:0] exp_t;
    inc = 16'h8040; ch_en = 2'b11;
    bring_up();
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL int_ready: ready=%b, required 1", ready);
    end
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      #1;
      exp_t = {(k % 2) == 0, (k % 4) == 0};
      checks++;
      if (tick !== exp_t) begin
        errors++;
        $display("FAIL int_rate add %0d: tick=%b, required %b", k, tick, exp_t);
      end
    end
  endtask

  task automatic test_boundary();
    logic [1:0] exp_t;
    inc = 16'h00FF; ch_en = 2'b11;
    bring_up();
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      exp_t = {1'b0, k >= 2};
      checks++;
      if (tick !== exp_t) begin
        errors++;
        $display("FAIL boundary add %0d: tick=%b, required %b", k, tick, exp_t);
      end
    end
  endtask

  task automatic test_enable_hold();
    logic [1:0] exp_t;
    inc = 16'h0040; ch_en = 2'b11;
    bring_up();
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      exp_t = {1'b0, (k == 4) || (k == 15) || (k == 19)};
      checks++;
      if (tick !== exp_t) begin
        errors++;
        $display("FAIL enable_hold edge %0d: tick=%b, required %b", k, tick, exp_t);
      end
      if (k == 5)  ch_en = 2'b10;
      if (k == 12) ch_en = 2'b11;
    end
  endtask

  task automatic test_lock_loss();
    inc = 16'h00FF; ch_en = 2'b01;
    bring_up();
    repeat (3) @(posedge clk);
    #1;
    locked_in = 1'b0;
    for (int i = 1; i <= SYNC + 1; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (i <= SYNC) begin
        if (ready !== 1'b1 || tick !== 2'b01 || lock_lost !== 1'b0) begin
          errors++;
          $display("FAIL loss_pipe %0d: ready=%b tick=%b lost=%b, required 1 01 0",
                   i, ready, tick, lock_lost);
        end
      end else if (ready !== 1'b0 || tick !== 2'b00 || lock_lost !== 1'b1) begin
        errors++;
        $display("FAIL loss_exit: ready=%b tick=%b lost=%b, required 0 00 1",
                 ready, tick, lock_lost);
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (lock_lost !== 1'b1) begin
      errors++;
      $display("FAIL loss_sticky: lock_lost=%b, required 1", lock_lost);
    end
    clr_lost = 1'b1;
    @(posedge clk);
    #1;
    clr_lost = 1'b0;
    checks++;
    if (lock_lost !== 1'b0) begin
      errors++;
      $display("FAIL loss_clear: lock_lost=%b, required 0", lock_lost);
    end
    locked_in = 1'b1;
    repeat (17 + SYNC) @(posedge clk);
    #1;
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL relock: ready=%b, required 1", ready);
    end
    locked_in = 1'b0;
    repeat (SYNC) @(posedge clk);
    #1;
    clr_lost = 1'b1;
    @(posedge clk);
    #1;
    clr_lost = 1'b0;
    checks++;
    if (lock_lost !== 1'b1 || ready !== 1'b0) begin
      errors++;
      $display("FAIL loss_vs_clear: lock_lost=%b ready=%b, required 1 0", lock_lost, ready);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (lock_lost !== 1'b0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: lock_lost=%b ready=%b, required 0 0", lock_lost, ready);
    end
  endtask

  task automatic test_fractional();
    int n_ticks, last, sp, min_sp, max_sp;
    longint unsigned exp_n;
    f_inc = FRAC_INC; f_ch_en = 1'b1; f_clr = 1'b0; f_rst = 1'b1; f_locked = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    f_rst = 1'b0; f_locked = 1'b1;
    repeat (17 + SYNC) @(posedge clk);
    #1;
    checks++;
    if (f_ready !== 1'b1) begin
      errors++;
      $display("FAIL frac_ready: ready=%b, required 1", f_ready);
    end
    n_ticks = 0; last = -1; min_sp = 1000000; max_sp = 0;
    for (int k = 1; k <= FRAC_N; k++) begin
      @(posedge clk);
      #1;
      if (f_tick === 1'b1) begin
        if (last >= 0) begin
          sp = k - last;
          if (sp < min_sp) min_sp = sp;
          if (sp > max_sp) max_sp = sp;
        end
        last = k;
        n_ticks++;
      end
    end
    exp_n = (longint'(FRAC_N) * longint'(FRAC_INC)) >> 32;
    checks++;
    if (longint'(n_ticks) != exp_n) begin
      errors++;
      $display("FAIL frac_count: ticks=%0d, required %0d", n_ticks, exp_n);
    end
    checks++;
    if (min_sp != 23 || max_sp != 24) begin
      errors++;
      $display("FAIL frac_spacing: min=%0d max=%0d, required 23 24", min_sp, max_sp);
    end
  endtask

  initial begin
    rst = 1'b1; locked_in = 1'b0; inc = '0; ch_en = '0; clr_lost = 1'b0;
    f_rst = 1'b1; f_locked = 1'b0; f_inc = '0; f_ch_en = '0; f_clr = 1'b0;
    test_reset();
    test_lockup();
    test_glitch();
    test_integer_rate();
    test_boundary();
    test_enable_hold();
    test_lock_loss();
    test_fractional();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
